// File: rtl/stage_id_fwd.sv
// RV32IM decode stage: decodes one instruction per accept and resolves operands through a forwarding network.
// Latency: an instruction accepted at edge n is presented on out_* with out_valid=1 after edge n.
// Backpressure: in_ready drops on a load-use hazard, on flush, or while a held output is not consumed.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_ready/in_inst/in_pc  fetch-side handshake and instruction
//   rf_raddr1/2, rf_rdata1/2         combinational register-file read port
//   fwd_valid/waddr/data/data_ok     NFWD forwarding sources, index 0 is youngest (EX)
//   flush                            kill the held and the incoming instruction
//   out_valid/out_ready/out_*        execute-side handshake and registered decode bundle
module stage_id_fwd #(
  parameter int XLEN = 32,
  parameter int NFWD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [XLEN-1:0]      in_pc,
  output logic [4:0]           rf_raddr1,
  output logic [4:0]           rf_raddr2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [5*NFWD-1:0]    fwd_waddr,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_data_ok,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_rs1v,
  output logic [XLEN-1:0]      out_rs2v,
  output logic [4:0]           out_rd,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_target,
  output logic [19:0]          out_dcr
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_J     = 7'b1101111;

  // ---------------- decode ----------------
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  logic is_r, is_ialu, is_load, is_jalr, is_s, is_u, is_b, is_j, is_auipc;
  logic is_mul, is_iany, is_shift;
  assign is_r     = (opc == OP_R);
  assign is_ialu  = (opc == OP_IALU);
  assign is_load  = (opc == OP_LOAD);
  assign is_jalr  = (opc == OP_JALR);
  assign is_s     = (opc == OP_S);
  assign is_auipc = (opc == OP_AUIPC);
  assign is_u     = (opc == OP_LUI) || is_auipc;
  assign is_b     = (opc == OP_B);
  assign is_j     = (opc == OP_J);
  assign is_mul   = is_r && (f3 == 3'b000) && (f7 == 7'b0000001);
  assign is_iany  = is_ialu || is_load || is_jalr;
  assign is_shift = (is_r || is_ialu) && (f3[1:0] == 2'b01);

  logic use_rs1, use_rs2, writes_rd;
  assign use_rs1   = is_r || is_iany || is_s || is_b;
  assign use_rs2   = is_r || is_s || is_b;
  assign writes_rd = is_r || is_iany || is_u || is_j;

  logic [2:0] alu_op;
  logic [1:0] sft_op;
  always_comb begin
    alu_op = 3'b000;
    if (is_r)         alu_op = f3 | {2'b00, f7[5]};
    else if (is_ialu) alu_op = f3;
    else if (is_b)    alu_op = {1'b0, f3[2], ~(f3[2] ^ f3[1])};
  end
  assign sft_op = {f3[2], f7[5]};

  logic signed [31:0] imm32;
  always_comb begin
    imm32 = '0;
    if (is_iany)   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
    else if (is_s) imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    else if (is_b) imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    else if (is_u) imm32 = {in_inst[31:12], 12'h000};
    else if (is_j) imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  end

  logic [XLEN-1:0] imm_d, tgt_sum, target_d;
  logic [4:0]      rd_d;
  logic [19:0]     dcr_d;
  assign imm_d    = XLEN'(imm32);
  assign tgt_sum  = in_pc + imm_d;
  assign target_d = {tgt_sum[XLEN-1:2], 2'b00};
  assign rd_d     = writes_rd ? in_inst[11:7] : 5'd0;
  assign dcr_d    = {is_auipc, f3, is_r, is_ialu, is_load, is_jalr, is_s, is_u, is_b, is_j, is_mul,
                     is_iany, is_shift, alu_op, sft_op};

  // ---------------- forwarding ----------------
  assign rf_raddr1 = in_inst[19:15];
  assign rf_raddr2 = in_inst[24:20];

  // Returns {hazard, value}. Scanning from the oldest source down lets the
  // youngest match overwrite, so the lowest matching index wins.
  function automatic logic [XLEN:0] resolve(
    input logic [4:0]           a,
    input logic [XLEN-1:0]      rf_val,
    input logic [NFWD-1:0]      v,
    input logic [5*NFWD-1:0]    wa,
    input logic [XLEN*NFWD-1:0] d,
    input logic [NFWD-1:0]      ok
  );
    logic [XLEN-1:0] val;
    logic            hz;
    val = rf_val;
    hz  = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (v[i] && (wa[5*i +: 5] == a)) begin
        val = d[XLEN*i +: XLEN];
        hz  = !ok[i];
      end
    end
    if (a == 5'd0) begin
      val = '0;
      hz  = 1'b0;
    end
    return {hz, val};
  endfunction

  logic [XLEN-1:0] rs1_d, rs2_d;
  logic            hz1, hz2;
  assign {hz1, rs1_d} = resolve(rf_raddr1, rf_rdata1, fwd_valid, fwd_waddr, fwd_data, fwd_data_ok);
  assign {hz2, rs2_d} = resolve(rf_raddr2, rf_rdata2, fwd_valid, fwd_waddr, fwd_data, fwd_data_ok);

  // ---------------- handshake ----------------
  logic valid_q, stall, accept;
  assign stall    = in_valid && ((use_rs1 && hz1) || (use_rs2 && hz2));
  assign in_ready = !stall && (!valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q, target_q;
  logic [4:0]      rd_q;
  logic [19:0]     dcr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      target_q <= '0;
      rd_q     <= '0;
      dcr_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      // Operands are captured only here; a held bundle is never re-forwarded.
      valid_q  <= 1'b1;
      pc_q     <= in_pc;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      target_q <= target_d;
      rd_q     <= rd_d;
      dcr_q    <= dcr_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid  = valid_q;
  assign out_pc     = pc_q;
  assign out_rs1v   = rs1_q;
  assign out_rs2v   = rs2_q;
  assign out_rd     = rd_q;
  assign out_imm    = imm_q;
  assign out_target = target_q;
  assign out_dcr    = dcr_q;

endmodule

// File: tb/tb_stage_id_fwd.sv
module tb_stage_id_fwd;
  localparam int NFWD = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_inst = '0;
  logic [31:0]       in_pc = '0;
  logic [4:0]        rf_raddr1, rf_raddr2;
  logic [31:0]       rf_rdata1, rf_rdata2;
  logic [NFWD-1:0]   fwd_valid = '0;
  logic [5*NFWD-1:0] fwd_waddr = '0;
  logic [32*NFWD-1:0] fwd_data = '0;
  logic [NFWD-1:0]   fwd_data_ok = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_pc, out_rs1v, out_rs2v, out_imm, out_target;
  logic [4:0]        out_rd;
  logic [19:0]       out_dcr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Register file model: xN reads 0xA500_00NN.
  assign rf_rdata1 = 32'hA500_0000 | 32'(rf_raddr1);
  assign rf_rdata2 = 32'hA500_0000 | 32'(rf_raddr2);

  stage_id_fwd #(.XLEN(32), .NFWD(NFWD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_waddr(fwd_waddr), .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1v(out_rs1v), .out_rs2v(out_rs2v), .out_rd(out_rd), .out_imm(out_imm),
    .out_target(out_target), .out_dcr(out_dcr)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc, rs1v, rs2v, imm, target;
    logic [4:0]  rd, a1, a2;
    logic [19:0] dcr;
    bit          use1, use2, is_bj;
  } exp_t;

  // ty: 0 nop, 1 R, 2 I_alu, 3 load, 4 jalr, 5 S, 6 U, 7 B, 8 J
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t        e;
    int          ty;
    logic [2:0]  f3, alu;
    logic        f75, mul, shift;
    logic [31:0] sx;
    f3  = inst[14:12];
    f75 = inst[30];
    sx  = $signed(inst) >>> 31;
    case (inst[6:0])
      7'h33: ty = 1;  7'h13: ty = 2;  7'h03: ty = 3;  7'h67: ty = 4;  7'h23: ty = 5;
      7'h37, 7'h17: ty = 6;  7'h63: ty = 7;  7'h6F: ty = 8;
      default: ty = 0;
    endcase
    case (ty)
      2, 3, 4: e.imm = $signed(inst) >>> 20;
      5: e.imm = (sx << 11) | (32'(inst[30:25]) << 5) | 32'(inst[11:7]);
      6: e.imm = inst & 32'hFFFF_F000;
      7: e.imm = (sx << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
      8: e.imm = (sx << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
      default: e.imm = 32'd0;
    endcase
    case (ty)
      1: alu = f3 | {2'b00, f75};
      2: alu = f3;
      7: case (f3[2:1]) 2'd0: alu = 3'd1; 2'd1: alu = 3'd0; 2'd2: alu = 3'd2; default: alu = 3'd3; endcase
      default: alu = 3'd0;
    endcase
    mul   = (ty == 1) && (f3 == 3'd0) && (inst[31:25] == 7'b0000001);
    shift = (ty == 1 || ty == 2) && (f3[1:0] == 2'b01);
    e.dcr = {(inst[6:0] == 7'h17), f3, ty == 1, ty == 2, ty == 3, ty == 4, ty == 5, ty == 6, ty == 7, ty == 8,
             mul, (ty inside {2, 3, 4}), shift, alu, f3[2], f75};
    e.use1   = ty inside {1, 2, 3, 4, 5, 7};
    e.use2   = ty inside {1, 5, 7};
    e.rd     = (ty inside {1, 2, 3, 4, 6, 8}) ? inst[11:7] : 5'd0;
    e.pc     = pc;
    e.target = (pc + e.imm) & ~32'd3;
    e.is_bj  = (ty == 7) || (ty == 8);
    e.a1     = inst[19:15];
    e.a2     = inst[24:20];
    e.rs1v   = 32'd0;
    e.rs2v   = 32'd0;
    return e;
  endfunction

  // First matching source in ascending (youngest-first) order decides.
  function automatic void model_opnd(input logic [4:0] a, output logic [31:0] v, output bit hz);
    v  = 32'hA500_0000 | 32'(a);
    hz = 1'b0;
    if (a == 5'd0) begin
      v = 32'd0;
      return;
    end
    for (int i = 0; i < NFWD; i++) begin
      if (fwd_valid[i] && fwd_waddr[5*i +: 5] == a) begin
        v  = fwd_data[32*i +: 32];
        hz = !fwd_data_ok[i];
        break;
      end
    end
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  op;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h67; 4: op = 7'h23;
      5: op = 7'h37; 6: op = 7'h17; 7: op = 7'h63; 8: op = 7'h6F; default: op = 7'h7F;
    endcase
    w[6:0]   = op;
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    if (op == 7'h33 || op == 7'h13) begin
      case ($urandom_range(0, 2))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: w[31:25] = 7'h01;
      endcase
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; fwd_valid = '0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL rst_pc got=%h exp=0", out_pc); end
    total++; if (out_rs1v !== 32'd0 || out_rs2v !== 32'd0) begin bad++; $display("FAIL rst_ops got=%h/%h exp=0", out_rs1v, out_rs2v); end
    total++; if (out_rd !== 5'd0 || out_imm !== 32'd0) begin bad++; $display("FAIL rst_rd_imm got=%h/%h exp=0", out_rd, out_imm); end
    total++; if (out_target !== 32'd0 || out_dcr !== 20'd0) begin bad++; $display("FAIL rst_tgt_dcr got=%h/%h exp=0", out_target, out_dcr); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0070_0293; in_pc = 32'h100;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL alu_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL alu_valid got=%b exp=1", out_valid); end
    total++; if (out_rd !== 5'd5) begin bad++; $display("FAIL alu_rd got=%0d exp=5", out_rd); end
    total++; if (out_imm !== 32'd7) begin bad++; $display("FAIL alu_imm got=%h exp=7", out_imm); end
    total++; if (out_rs1v !== 32'd0) begin bad++; $display("FAIL alu_rs1v got=%h exp=0", out_rs1v); end
    total++; if (out_pc !== 32'h100) begin bad++; $display("FAIL alu_pc got=%h exp=100", out_pc); end
    total++; if (out_dcr !== 20'h04040) begin bad++; $display("FAIL alu_dcr got=%h exp=04040", out_dcr); end
    drain();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL alu_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_ex_fwd();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0052_8333; in_pc = 32'h180;
    fwd_valid = 2'b01; fwd_waddr = {5'd0, 5'd5}; fwd_data = {32'h0, 32'h11}; fwd_data_ok = 2'b11;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fwd_in_ready0 got=%b exp=1", in_ready); end
    tick();
    total++; if (out_rs1v !== 32'h11 || out_rs2v !== 32'h11) begin bad++; $display("FAIL fwd_ex got=%h/%h exp=11/11", out_rs1v, out_rs2v); end
    total++; if (out_rd !== 5'd6) begin bad++; $display("FAIL fwd_rd got=%0d exp=6", out_rd); end
    // Back-to-back: both stages hold x5, youngest must win.
    in_pc = 32'h184; fwd_valid = 2'b11; fwd_waddr = {5'd5, 5'd5}; fwd_data = {32'h22, 32'h11};
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fwd_in_ready1 got=%b exp=1", in_ready); end
    tick();
    total++; if (out_pc !== 32'h184 || out_rs1v !== 32'h11) begin bad++; $display("FAIL fwd_prio got=%h/%h exp=184/11", out_pc, out_rs1v); end
    in_pc = 32'h188; fwd_valid = 2'b10;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fwd_in_ready2 got=%b exp=1", in_ready); end
    tick();
    total++; if (out_pc !== 32'h188 || out_rs2v !== 32'h22) begin bad++; $display("FAIL fwd_old got=%h/%h exp=188/22", out_pc, out_rs2v); end
    drain();
  endtask

  task automatic test_load_use();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0070_0293; in_pc = 32'h300;
    tick();
    in_inst = 32'h0052_8333; in_pc = 32'h304;
    fwd_valid = 2'b01; fwd_waddr = {5'd0, 5'd5}; fwd_data = {32'h0, 32'h0}; fwd_data_ok = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_stall k=%0d got=%b exp=0", k, in_ready); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble k=%0d got=%b exp=0", k, out_valid); end
    end
    fwd_data_ok = 2'b01; fwd_data = {32'h0, 32'hABCD};
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_release got=%b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h304) begin bad++; $display("FAIL lu_accept got=%b/%h exp=1/304", out_valid, out_pc); end
    total++; if (out_rs1v !== 32'hABCD) begin bad++; $display("FAIL lu_rs1v got=%h exp=abcd", out_rs1v); end
    drain();
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFE20_8CE3; in_pc = 32'h200;
    tick();
    in_inst = 32'h0000_0013; in_pc = 32'h204;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready k=%0d got=%b exp=0", k, in_ready); end
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_target !== 32'h1F8) begin
        bad++; $display("FAIL bp_hold k=%0d got=%b/%h/%h exp=1/200/1f8", k, out_valid, out_pc, out_target); end
      tick();
    end
    total++; if (out_imm !== 32'hFFFF_FFF8 || out_dcr !== 20'h00205) begin bad++; $display("FAIL bp_dec got=%h/%h exp=fffffff8/00205", out_imm, out_dcr); end
    total++; if (out_rs1v !== 32'hA500_0001 || out_rs2v !== 32'hA500_0002) begin bad++; $display("FAIL bp_ops got=%h/%h exp=a5000001/a5000002", out_rs1v, out_rs2v); end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (out_valid && out_ready) n++;
      tick();
    end
    total++; if (n != 1) begin bad++; $display("FAIL bp_xfers got=%0d exp=1", n); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0070_0293; in_pc = 32'h400;
    tick();
    in_pc = 32'h404; flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_in_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_kill got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_noemit got=%b exp=0", out_valid); end
    in_valid = 1'b1; in_pc = 32'h408;
    tick();
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b0;
    tick();
    flush = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_held got=%b exp=0", out_valid); end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0070_0293; in_pc = 32'h500;
    tick();
    in_inst = 32'h0052_8333; in_pc = 32'h504;
    fwd_valid = 2'b01; fwd_waddr = {5'd0, 5'd5}; fwd_data_ok = 2'b00;
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || out_pc !== 32'd0) begin bad++; $display("FAIL rmid_clear got=%b/%h exp=0/0", out_valid, out_pc); end
    tick();
    rst = 1'b0; in_valid = 1'b0; fwd_valid = '0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_emit k=%0d got=%b exp=0", k, out_valid); end
    end
  endtask

  // ---------------- randomized stream ----------------
  task automatic test_random();
    exp_t        mb, cur;
    bit          mvalid, h1, h2, stall, exp_rdy, do_acc, held;
    logic [31:0] pc_ctr;
    logic [31:0] acc_pcs[$];
    logic [31:0] dut_pcs[$];
    mvalid = 1'b0; held = 1'b0; pc_ctr = 32'h1000;
    mb = ref_decode(32'h0, 32'h0);
    for (int c = 0; c < 1500; c++) begin
      if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if (in_valid) begin
          pc_ctr += 4; in_pc = pc_ctr; in_inst = rand_inst();
        end
      end
      for (int i = 0; i < NFWD; i++) begin
        fwd_valid[i] = 1'($urandom_range(0, 1));
        fwd_waddr[5*i +: 5] = 5'($urandom_range(0, 7));
        fwd_data[32*i +: 32] = $urandom;
        fwd_data_ok[i] = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      cur = ref_decode(in_inst, in_pc);
      model_opnd(cur.a1, cur.rs1v, h1);
      model_opnd(cur.a2, cur.rs2v, h2);
      stall   = in_valid && ((cur.use1 && h1) || (cur.use2 && h2));
      exp_rdy = !stall && (!mvalid || out_ready);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
      total++; if (rf_raddr1 !== cur.a1 || rf_raddr2 !== cur.a2) begin bad++; $display("FAIL rnd_raddr c=%0d got=%0d/%0d exp=%0d/%0d", c, rf_raddr1, rf_raddr2, cur.a1, cur.a2); end
      total++; if (out_valid !== mvalid) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, mvalid); end
      if (mvalid) begin
        total++; if (out_pc !== mb.pc || out_rd !== mb.rd || out_imm !== mb.imm || out_dcr !== mb.dcr) begin
          bad++; $display("FAIL rnd_bundle c=%0d got=%h/%0d/%h/%h exp=%h/%0d/%h/%h", c, out_pc, out_rd, out_imm, out_dcr, mb.pc, mb.rd, mb.imm, mb.dcr); end
        if (mb.use1) begin
          total++; if (out_rs1v !== mb.rs1v) begin bad++; $display("FAIL rnd_rs1v c=%0d got=%h exp=%h", c, out_rs1v, mb.rs1v); end
        end
        if (mb.use2) begin
          total++; if (out_rs2v !== mb.rs2v) begin bad++; $display("FAIL rnd_rs2v c=%0d got=%h exp=%h", c, out_rs2v, mb.rs2v); end
        end
        if (mb.is_bj) begin
          total++; if (out_target !== mb.target) begin bad++; $display("FAIL rnd_target c=%0d got=%h exp=%h", c, out_target, mb.target); end
        end
      end
      if (out_valid === 1'b1 && out_ready) dut_pcs.push_back(out_pc);
      do_acc = in_valid && exp_rdy;
      @(posedge clk);
      if (do_acc) begin
        mb = cur; mvalid = 1'b1; acc_pcs.push_back(in_pc);
      end else if (out_ready) begin
        mvalid = 1'b0;
      end
      held = in_valid && !do_acc;
      #1;
    end
    in_valid = 1'b0; fwd_valid = '0; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      if (out_valid === 1'b1) dut_pcs.push_back(out_pc);
      tick();
    end
    total++; if (dut_pcs.size() != acc_pcs.size()) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", dut_pcs.size(), acc_pcs.size()); end
    for (int k = 0; k < acc_pcs.size() && k < dut_pcs.size(); k++) begin
      total++; if (dut_pcs[k] !== acc_pcs[k]) begin bad++; $display("FAIL rnd_order k=%0d got=%h exp=%h", k, dut_pcs[k], acc_pcs[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ex_fwd();
    test_load_use();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_id_fwd.md
# stage_id_fwd

Parametrised RV32IM instruction-decode stage for the pipelined CPU, sitting between the fetch stage and the execute stage. It adds elastic valid/ready handshakes on both sides, a forwarding network over `NFWD` later pipeline stages, load-use stall detection and a flush input. It decodes one instruction per accepted cycle into a registered bundle of operands, immediate, destination and decode flags.

## Interface
Parameters:
- `XLEN`, 32: datapath and PC width.
- `NFWD`, 2: number of forwarding sources; index 0 is the youngest stage (EX), ascending index is older.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  fetch holds a valid instruction.
- `in_ready`  out  1  decode accepts this cycle.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  XLEN  instruction PC.
- `rf_raddr1`, `rf_raddr2`  out  5  regfile read addresses, driven from `in_inst[19:15]` and `in_inst[24:20]`.
- `rf_rdata1`, `rf_rdata2`  in  XLEN  combinational regfile read data.
- `fwd_valid`  in  NFWD  stage i holds an instruction that writes a register.
- `fwd_waddr`  in  5*NFWD  destination of stage i, in slice `[5i+4:5i]`.
- `fwd_data`  in  XLEN*NFWD  result of stage i.
- `fwd_data_ok`  in  NFWD  `fwd_data[i]` is final; 0 for a load whose data has not returned.
- `flush`  in  1  branch/jump redirect: kill the decoded and incoming instruction.
- `out_valid`  out  1  output bundle valid.
- `out_ready`  in  1  execute accepts the bundle.
- `out_pc`  out  XLEN  PC of the bundle.
- `out_rs1v`, `out_rs2v`  out  XLEN  resolved operand values.
- `out_rd`  out  5  write address; 0 if the instruction does not write.
- `out_imm`  out  XLEN  sign-extended immediate.
- `out_target`  out  XLEN  `(pc + imm)` with bits [1:0] cleared. Valid for B and JAL only; JALR targets are resolved in EX.
- `out_dcr`  out  20  decode flags: [19] auipc, [18:16] funct3, [15:7] {R, I_alu, I_load, jalr, S, U, B, J, MUL}, [6] I-any, [5] shift, [4:2] alu_op, [1:0] sft_op.

## Operation
- Decode is combinational on `in_inst`.
  - Opcodes: R=0110011, I_alu=0010011, I_load=0000011, jalr=1100111, S=0100011, U={lui, auipc}, B=1100011, J=1101111.
  - MUL: R with funct3=0 and funct7=0000001.
  - Immediate uses the standard I/S/B/U/J format for the type. All other opcodes produce imm=0 and all type flags 0 (treated as a NOP).
- Operand use:
  - rs1 is used by R, I_*, jalr, S, B.
  - rs2 is used by R, S, B.
  - Unused operands never cause a stall.
- `alu_op`:
  - R: funct3 | {00, funct7[5]}.
  - I_alu: funct3.
  - B: {0, f3[2], ~(f3[2]^f3[1])}.
  - All other types: ADD (000).
- `sft_op` = {funct3[2], funct7[5]}. Shift flag = (R or I_alu) and funct3[1:0]=01.
- Forwarding, per operand with address a≠0:
  - Match i: `fwd_valid[i]` and `fwd_waddr[i]==a`.
  - The lowest matching index wins.
  - If the winner has `fwd_data_ok[i]`=1, use `fwd_data[i]`. Otherwise the operand is a hazard.
  - With no match, use `rf_rdata`. Address 0 always yields 0.
- `stall` = `in_valid` and (rs1 hazard or rs2 hazard).
- `in_ready` = !stall and (!`out_valid` or `out_ready`) and !`flush`.
- Accept (`in_valid` and `in_ready`): load every out_* register from the decode and forwarding results; set `out_valid`=1.
- Output consumed and no accept: clear `out_valid`. This inserts a bubble during a stall.
- Not consumed: hold every output register unchanged.
- `flush`=1: next cycle `out_valid`=0; the incoming instruction is not accepted. Flush wins over all simultaneous events.

## Timing
- Reset: `out_valid`=0 and all out_* registers 0, immediately on the rst assertion edge, independent of clk.
- Latency: an instruction accepted at edge n is visible with `out_valid`=1 after edge n.
- `in_ready` is combinational from `out_ready`, `flush`, `fwd_*` and `in_inst`.
- No duplicate and no lost instruction under any `out_ready` pattern: one accept produces exactly one output transfer.
- Back-to-back dependency (EX producer, not a load): forwarded with zero stall.
- Load-use: stall lasts while `fwd_data_ok[i]`=0; accept happens in the first cycle it becomes 1.
- Operands are captured at accept only; a held output is not re-forwarded.
- rst asserted mid-stall or mid-hold: all state cleared; no instruction is emitted after rst deasserts until a new accept.

## Test plan
- Reset and simple ALU: assert rst, then `addi x5,x0,7` (0x00700293) at pc 0x100 -> one cycle later out_valid=1, out_rd=5, out_imm=7, out_rs1v=0, alu_op=000; before reset all outputs read 0.
- EX forward: fwd_valid[0]=1, waddr=5, data=0x11, ok=1; `add x6,x5,x5` -> accepted with no stall, out_rs1v=out_rs2v=0x11; with the same x5 also in stage 1 (data 0x22), stage 0 still wins.
- Load-use stall: fwd_valid[0]=1, waddr=5, ok=0 for 3 cycles -> in_ready=0 for 3 cycles and out_valid drops after the first consume; ok=1 with data 0xABCD -> accepted, out_rs1v=0xABCD.
- Backpressure: out_ready=0 for 4 cycles with `beq x1,x2,-8` at pc 0x200 -> outputs held and in_ready=0; then out_ready=1 -> exactly one transfer with out_target=0x1F8.
- Flush: flush=1 while in_valid=1 and out_valid=1 -> next cycle out_valid=0 and the instruction is not accepted; flush together with out_ready=0 also clears.
- Random: random instruction stream, ready and valid patterns against a reference model -> no dropped or duplicated PCs; x0 operands are always 0.
